encoder_req_sched: RTL and testbench
====================================

# encoder_req_sched

Schedules read transactions on the absolute-encoder serial transceiver and publishes a coherent 64-bit frame snapshot plus inter-frame interval to the DSP bus register file. Requests come from two sources: a DSP-triggered pulse (the `read_begin` strobe raised by the bus interface) and an internal periodic timer. The block arbitrates between them, issues one transaction at a time, supervises completion with a timeout, and counts errors. It sits between the DSP bus register block (consumer of `rx_data` and `time_interval`) and the encoder transceiver.

## Interface
- `CLK_MHZ`, default 30: clock frequency in MHz; sets the 1 µs prescaler.
- `TIMEOUT_CYC`, default 3000: clock cycles allowed in WAIT before the transaction is abandoned (100 µs at 30 MHz).
- `clk_in` in 1: system clock, 30 MHz.
- `rst_n_in` in 1: asynchronous active-low reset.
- `dsp_req` in 1: one-cycle request pulse from the bus interface.
- `auto_en` in 1: enables periodic requests.
- `auto_period` in 16: periodic request spacing in clock cycles; 0 means periodic requests are disabled.
- `err_clr` in 1: one-cycle pulse; clears `timeout_err` and `err_cnt`.
- `tx_start` out 1: one-cycle pulse that starts a transceiver frame.
- `rx_done` in 1: one-cycle pulse from the transceiver; the frame is complete.
- `rx_crc_err` in 1: qualifies `rx_done`; 1 means the frame is bad.
- `rx_frame` in 64: transceiver frame, valid while `rx_done` = 1.
- `rx_data` out 64: last good frame snapshot.
- `data_valid` out 1: one-cycle pulse when `rx_data` updates.
- `time_interval` out 8: µs between the last two good frames, saturating at 255.
- `busy` out 1: high in START and WAIT.
- `last_src` out 1: source of the last completed transaction; 1 = DSP, 0 = timer.
- `timeout_err` out 1: sticky timeout flag.
- `err_cnt` out 8: count of timeouts plus CRC errors, saturating at 255.

## Operation
- Pending flags:
  - `dsp_pend` sets on `dsp_req`. `auto_pend` sets on timer expiry.
  - Each flag is one deep; further requests while the flag is set are merged into it.
  - Both flags clear when a transaction is launched. Requests arriving in START or WAIT re-set their flag and are served afterwards.
- Periodic timer:
  - Counts clock cycles while `auto_en` = 1 and `auto_period` ≠ 0.
  - When the count reaches `auto_period`−1 it sets `auto_pend` and reloads to 0.
  - When disabled, the count is held at 0.
- Arbitration: when both flags are set, DSP wins. `last_src` records the winner; for a merged launch it reads 1.
- State machine, all outputs registered:
  - IDLE: go to START if either flag is set.
  - START: `tx_start` = 1 for this cycle only; clear both flags; clear the timeout counter; go to WAIT.
  - WAIT: increment the timeout counter each cycle.
    - `rx_done` with `rx_crc_err` = 0: load `rx_data` from `rx_frame`, pulse `data_valid`, update `time_interval`, go to IDLE.
    - `rx_done` with `rx_crc_err` = 1: increment `err_cnt`, keep `rx_data`, go to IDLE.
    - Timeout counter reaches `TIMEOUT_CYC`−1 without `rx_done`: set `timeout_err`, increment `err_cnt`, go to IDLE.
- Interval measurement:
  - A 1 µs prescaler (`CLK_MHZ` cycles) drives a µs counter that saturates at 255.
  - On each good frame, `time_interval` takes the counter value and the counter and prescaler restart at 0.
  - CRC errors and timeouts do not restart it.
- Reset mid-transaction: everything returns to reset values immediately. A late `rx_done` arriving in IDLE is ignored.

## Timing
- Reset values:
  - `tx_start`, `data_valid`, `busy`, `last_src`, `timeout_err` = 0.
  - `rx_data`, `time_interval`, `err_cnt` = 0.
  - State = IDLE; both pending flags, the timer and the µs counter are cleared.
- Request to launch: `dsp_req` sampled high at edge k → `tx_start` = 1 in cycle k+2 (k+1 sets the flag, k+2 is START). `busy` = 1 from k+2.
- Completion: `rx_done` sampled at edge m → `rx_data`, `data_valid` and `time_interval` update at edge m+1. `busy` = 0 and state = IDLE from m+1.
- Back-to-back: a flag pending at completion gives the next `tx_start` at m+2.
- Coincident events:
  - `rx_done` in the same cycle as timeout expiry: `rx_done` wins and no timeout is recorded.
  - `err_clr` in the same cycle as a new error: the error wins, giving `err_cnt` = 1 and `timeout_err` set.
  - `dsp_req` and timer expiry in the same cycle: one transaction, `last_src` = 1.
- `err_cnt` holds at 255; `time_interval` holds at 255.
- `rx_data` changes only on the `data_valid` cycle, so bus reads of its bytes are coherent between pulses.

## Test plan
- Reset, then a single `dsp_req` at cycle 10, then `rx_done` at cycle 40 with `rx_frame` = 64'h0123_4567_89AB_CDEF and `rx_crc_err` = 0 → `tx_start` at cycle 12, `rx_data` = 64'h0123_4567_89AB_CDEF and `data_valid` at cycle 41, `last_src` = 1, `time_interval` = 1 (41 cycles ≈ 1 µs).
- `auto_en` = 1, `auto_period` = 300, transceiver model answering 20 cycles after `tx_start` → `tx_start` every 300 cycles, `time_interval` = 10, `last_src` = 0, `err_cnt` = 0.
- Transceiver silent → `timeout_err` = 1 and `err_cnt` = 1 exactly 3000 cycles after WAIT is entered; `rx_data` unchanged; a subsequent `err_clr` → both cleared.
- `rx_done` with `rx_crc_err` = 1 → `err_cnt` increments, no `data_valid`, `rx_data` and `time_interval` unchanged. Run 300 such frames → `err_cnt` saturates at 255.
- `dsp_req` and timer expiry in the same cycle, plus a second `dsp_req` during WAIT → first launch `last_src` = 1, second `tx_start` at m+2 after the first `rx_done`, exactly two transactions in total.
- Deassert `rst_n_in` during WAIT, then pulse `rx_done` → all outputs at reset values, `rx_done` ignored, no `data_valid`.

Source files
------------

// File: rtl/encoder_req_sched.sv
// Absolute-encoder read scheduler: arbitrates DSP and periodic requests, supervises
// one transceiver transaction at a time, publishes a coherent frame snapshot and interval.
module encoder_req_sched #(
    parameter int unsigned CLK_MHZ     = 30,
    parameter int unsigned TIMEOUT_CYC = 3000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        dsp_req,
    input  logic        auto_en,
    input  logic [15:0] auto_period,
    input  logic        err_clr,
    output logic        tx_start,
    input  logic        rx_done,
    input  logic        rx_crc_err,
    input  logic [63:0] rx_frame,
    output logic [63:0] rx_data,
    output logic        data_valid,
    output logic [7:0]  time_interval,
    output logic        busy,
    output logic        last_src,
    output logic        timeout_err,
    output logic [7:0]  err_cnt
);

    localparam int unsigned TO_W_RAW  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned TO_W      = (TO_W_RAW > 0) ? TO_W_RAW : 1;
    localparam int unsigned PRE_W_RAW = $clog2(CLK_MHZ + 1);
    localparam int unsigned PRE_W     = (PRE_W_RAW > 0) ? PRE_W_RAW : 1;
    localparam int unsigned TMR_W     = 16;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             state;
    logic               dsp_pend;
    logic               auto_pend;
    logic               cur_src;
    logic [TO_W-1:0]    to_cnt;
    logic [TMR_W-1:0]   tmr;
    logic [PRE_W-1:0]   pre;
    logic [CNT_W-1:0]   us_cnt;

    logic               timer_run_c;
    logic               timer_hit_c;
    logic               us_tick_c;
    logic [CNT_W-1:0]   us_nxt_c;
    logic               good_c;
    logic               to_expire_c;
    logic [CNT_W-1:0]   err_base_c;
    logic [CNT_W-1:0]   err_inc_c;

    // Periodic request timer
    assign timer_run_c = auto_en && (auto_period != '0);
    assign timer_hit_c = timer_run_c && (tmr == (auto_period - TMR_W'(1)));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tmr <= '0;
        end else if (!timer_run_c || timer_hit_c) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + TMR_W'(1);
        end
    end

    // Microsecond interval counter; the captured value includes the current edge's tick
    assign us_tick_c = (pre == PRE_W'(CLK_MHZ - 1));
    assign us_nxt_c  = (us_tick_c && (us_cnt != {CNT_W{1'b1}})) ? us_cnt + CNT_W'(1) : us_cnt;
    assign good_c    = (state == S_WAIT) && rx_done && !rx_crc_err;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pre    <= '0;
            us_cnt <= '0;
        end else if (good_c) begin
            pre    <= '0;
            us_cnt <= '0;
        end else begin
            pre    <= us_tick_c ? '0 : pre + PRE_W'(1);
            us_cnt <= us_nxt_c;
        end
    end

    // A clear coincident with a new error yields a count of exactly one
    assign to_expire_c = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign err_base_c  = err_clr ? '0 : err_cnt;
    assign err_inc_c   = (err_base_c == {CNT_W{1'b1}}) ? err_base_c : err_base_c + CNT_W'(1);

    // Transaction sequencer with registered outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= S_IDLE;
            dsp_pend      <= 1'b0;
            auto_pend     <= 1'b0;
            cur_src       <= 1'b0;
            to_cnt        <= '0;
            tx_start      <= 1'b0;
            rx_data       <= '0;
            data_valid    <= 1'b0;
            time_interval <= '0;
            busy          <= 1'b0;
            last_src      <= 1'b0;
            timeout_err   <= 1'b0;
            err_cnt       <= '0;
        end else begin
            tx_start   <= 1'b0;
            data_valid <= 1'b0;
            dsp_pend   <= dsp_pend | dsp_req;
            auto_pend  <= auto_pend | timer_hit_c;
            if (err_clr) begin
                timeout_err <= 1'b0;
                err_cnt     <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (dsp_pend || auto_pend) begin
                        state    <= S_START;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        cur_src  <= dsp_pend;
                    end
                end

                S_START: begin
                    // Launch consumes both flags; requests in this cycle re-arm them
                    dsp_pend  <= dsp_req;
                    auto_pend <= timer_hit_c;
                    to_cnt    <= '0;
                    state     <= S_WAIT;
                end

                S_WAIT: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (rx_done) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        last_src <= cur_src;
                        if (!rx_crc_err) begin
                            rx_data       <= rx_frame;
                            data_valid    <= 1'b1;
                            time_interval <= us_nxt_c;
                        end else begin
                            err_cnt <= err_inc_c;
                        end
                    end else if (to_expire_c) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        last_src    <= cur_src;
                        timeout_err <= 1'b1;
                        err_cnt     <= err_inc_c;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_req_sched.sv
// Directed self-checking bench for encoder_req_sched.
module tb_encoder_req_sched;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        dsp_req;
    logic        auto_en;
    logic [15:0] auto_period;
    logic        err_clr;
    logic        tx_start;
    logic        rx_done;
    logic        rx_crc_err;
    logic [63:0] rx_frame;
    logic [63:0] rx_data;
    logic        data_valid;
    logic [7:0]  time_interval;
    logic        busy;
    logic        last_src;
    logic        timeout_err;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;
    int tx_cnt = 0;
    int dv_cnt = 0;
    int cyc    = 0;

    encoder_req_sched #(.CLK_MHZ(30), .TIMEOUT_CYC(3000)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .dsp_req       (dsp_req),
        .auto_en       (auto_en),
        .auto_period   (auto_period),
        .err_clr       (err_clr),
        .tx_start      (tx_start),
        .rx_done       (rx_done),
        .rx_crc_err    (rx_crc_err),
        .rx_frame      (rx_frame),
        .rx_data       (rx_data),
        .data_valid    (data_valid),
        .time_interval (time_interval),
        .busy          (busy),
        .last_src      (last_src),
        .timeout_err   (timeout_err),
        .err_cnt       (err_cnt)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc++;

    always @(negedge clk_in) begin
        if (tx_start) tx_cnt++;
        if (data_valid) dv_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_tx(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (tx_start) break;
        end
        check(tag, 64'(tx_start), 64'd1);
    endtask

    task automatic launch_dsp(input string tag);
        dsp_req = 1'b1;
        tick();
        dsp_req = 1'b0;
        wait_tx(tag, 8);
    endtask

    task automatic frame(input logic crc, input logic [63:0] f);
        rx_done    = 1'b1;
        rx_crc_err = crc;
        rx_frame   = f;
        tick();
        rx_done    = 1'b0;
        rx_crc_err = 1'b0;
        rx_frame   = '0;
    endtask

    initial begin
        logic [63:0] last_good;
        int          prev_t;
        int          now_t;
        int          dv0;
        int          tx0;

        rst_n_in    = 1'b0;
        dsp_req     = 1'b0;
        auto_en     = 1'b0;
        auto_period = '0;
        err_clr     = 1'b0;
        rx_done     = 1'b0;
        rx_crc_err  = 1'b0;
        rx_frame    = '0;
        prev_t      = 0;

        repeat (3) tick();
        check("rst_tx_start", 64'(tx_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rx_data", rx_data, 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        rst_n_in = 1'b1;

        // Single DSP read; frame sampled at the 40th edge after reset release
        repeat (9) tick();
        dsp_req = 1'b1;
        tick();
        dsp_req = 1'b0;
        check("t1_no_early_tx", 64'(tx_start), 64'd0);
        tick();
        check("t1_tx_start", 64'(tx_start), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        tick();
        check("t1_tx_one_cycle", 64'(tx_start), 64'd0);
        check("t1_busy_wait", 64'(busy), 64'd1);
        repeat (27) tick();
        frame(1'b0, 64'h0123_4567_89AB_CDEF);
        check("t1_rx_data", rx_data, 64'h0123_4567_89AB_CDEF);
        check("t1_data_valid", 64'(data_valid), 64'd1);
        check("t1_busy_done", 64'(busy), 64'd0);
        check("t1_last_src", 64'(last_src), 64'd1);
        check("t1_interval", 64'(time_interval), 64'd1);
        tick();
        check("t1_dv_pulse", 64'(data_valid), 64'd0);

        // Periodic reads every 300 cycles, transceiver answering 20 cycles after tx_start
        auto_period = 16'd300;
        auto_en     = 1'b1;
        last_good   = '0;
        for (int i = 0; i < 4; i++) begin
            wait_tx("t2_tx", 400);
            now_t = cyc;
            if (i > 0) check("t2_period", 64'(now_t - prev_t), 64'd300);
            prev_t = now_t;
            repeat (19) tick();
            last_good = 64'hA5A5_0000_0000_0000 | 64'(i);
            frame(1'b0, last_good);
            check("t2_dv", 64'(data_valid), 64'd1);
            if (i > 0) check("t2_interval", 64'(time_interval), 64'd10);
            check("t2_last_src", 64'(last_src), 64'd0);
            check("t2_err_cnt", 64'(err_cnt), 64'd0);
        end
        auto_en = 1'b0;
        repeat (2) tick();

        // Silent transceiver: timeout exactly 3000 cycles after entering WAIT
        launch_dsp("t3_launch");
        repeat (3000) tick();
        check("t3_no_early_to", 64'(timeout_err), 64'd0);
        check("t3_busy", 64'(busy), 64'd1);
        tick();
        check("t3_timeout_err", 64'(timeout_err), 64'd1);
        check("t3_err_cnt", 64'(err_cnt), 64'd1);
        check("t3_idle", 64'(busy), 64'd0);
        check("t3_rx_data_kept", rx_data, last_good);

        // Clear coincident with a second timeout: the new error wins
        launch_dsp("t3_launch2");
        repeat (3000) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_clr_vs_err_cnt", 64'(err_cnt), 64'd1);
        check("t3_clr_vs_err_flag", 64'(timeout_err), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_clr_flag", 64'(timeout_err), 64'd0);
        check("t3_clr_cnt", 64'(err_cnt), 64'd0);

        // CRC-error frames: count saturates, snapshot and interval untouched
        dv0 = dv_cnt;
        for (int i = 0; i < 300; i++) begin
            launch_dsp("t4_launch");
            tick();
            frame(1'b1, 64'hDEAD_BEEF_0000_0000 + 64'(i));
            if (i == 0) begin
                check("t4_err_cnt_1", 64'(err_cnt), 64'd1);
                check("t4_no_dv", 64'(data_valid), 64'd0);
            end
            if (i == 254) check("t4_err_cnt_255", 64'(err_cnt), 64'd255);
        end
        check("t4_err_cnt_sat", 64'(err_cnt), 64'd255);
        check("t4_rx_data_kept", rx_data, last_good);
        check("t4_interval_kept", 64'(time_interval), 64'd10);
        check("t4_dv_count", 64'(dv_cnt - dv0), 64'd0);

        // DSP request coincident with timer expiry, plus a DSP request during WAIT
        tx0         = tx_cnt;
        auto_period = 16'd50;
        auto_en     = 1'b1;
        repeat (49) tick();
        dsp_req = 1'b1;
        tick();
        dsp_req = 1'b0;
        auto_en = 1'b0;
        tick();
        check("t5_tx_first", 64'(tx_start), 64'd1);
        tick();
        dsp_req = 1'b1;
        tick();
        dsp_req = 1'b0;
        repeat (5) tick();
        frame(1'b0, 64'h1111_2222_3333_4444);
        check("t5_last_src", 64'(last_src), 64'd1);
        check("t5_dv", 64'(data_valid), 64'd1);
        tick();
        check("t5_b2b_tx", 64'(tx_start), 64'd1);
        tick();
        frame(1'b0, 64'h5555_6666_7777_8888);
        check("t5_rx_data2", rx_data, 64'h5555_6666_7777_8888);
        repeat (100) tick();
        check("t5_tx_total", 64'(tx_cnt - tx0), 64'd2);

        // Reset during WAIT, then a late rx_done
        launch_dsp("t6_launch");
        repeat (2) tick();
        rst_n_in = 1'b0;
        #2;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_rx_data", rx_data, 64'd0);
        check("t6_rst_last_src", 64'(last_src), 64'd0);
        check("t6_rst_err_cnt", 64'(err_cnt), 64'd0);
        check("t6_rst_interval", 64'(time_interval), 64'd0);
        dv0 = dv_cnt;
        tx0 = tx_cnt;
        tick();
        rst_n_in = 1'b1;
        frame(1'b0, 64'hBAD0_BAD0_BAD0_BAD0);
        check("t6_late_no_dv", 64'(data_valid), 64'd0);
        check("t6_late_rx_data", rx_data, 64'd0);
        check("t6_late_busy", 64'(busy), 64'd0);
        tick();
        check("t6_dv_count", 64'(dv_cnt - dv0), 64'd0);
        check("t6_tx_count", 64'(tx_cnt - tx0), 64'd0);

        // Long gap: interval saturates at 255 us
        repeat (8000) tick();
        launch_dsp("t7_launch");
        tick();
        frame(1'b0, 64'hCAFE_F00D_0000_0001);
        check("t7_interval_sat", 64'(time_interval), 64'd255);
        check("t7_rx_data", rx_data, 64'hCAFE_F00D_0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
